// File: rtl/speed_display.sv
// Speed word to 4-digit multiplexed 7-segment display: handshake, clamp to 9999, double-dabble BCD, refresh scan.
// Optional macro SPEED_DISPLAY_BLANK_EN blanks leading zeros on the thousands, hundreds and tens digits.
module speed_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] input_speed,
   input  logic        input_speed_stb,
   output logic        input_speed_ack,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   localparam logic [15:0] LP_LAST = 16'(REFRESH_DIV - 1);

   state_t      r_state;
   logic [15:0] r_bin;
   logic [15:0] r_bcd;
   logic [3:0]  r_bit_cnt;
   logic [15:0] r_disp;
   logic        r_ack;
   logic [15:0] r_refresh_cnt;
   logic [1:0]  r_digit_idx;
   logic [6:0]  r_seg;
   logic [3:0]  r_an;

   logic        w_wrap;
   logic [1:0]  w_idx_nxt;
   logic [15:0] w_disp_nxt;
   logic [3:0]  w_digit;
   logic        w_blank;

   function automatic logic [15:0] clamp_9999(input logic [15:0] v);
      return (v > 16'd9999) ? 16'd9999 : v;
   endfunction

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
   function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic msb);
      logic [15:0] adj;
      adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
      return {adj[14:0], msb};
   endfunction

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ack   <= 1'b1;
         r_disp  <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (input_speed_stb && r_ack) begin
                  r_bin     <= clamp_9999(input_speed);
                  r_bcd     <= 16'h0000;
                  r_bit_cnt <= 4'd0;
                  r_ack     <= 1'b0;
                  r_state   <= CONVERT;
               end
            end
            CONVERT: begin
               r_bcd     <= dd_step(r_bcd, r_bin[15]);
               r_bin     <= {r_bin[14:0], 1'b0};
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd15) r_state <= LOAD;
            end
            LOAD: begin
               r_disp  <= r_bcd;
               r_ack   <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_ack   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from next-cycle index and display so an and seg always change together.
   always_comb begin
      w_wrap     = (r_refresh_cnt == LP_LAST);
      w_idx_nxt  = w_wrap ? r_digit_idx + 2'd1 : r_digit_idx;
      w_disp_nxt = (r_state == LOAD) ? r_bcd : r_disp;
      case (w_idx_nxt)
         2'd0:    w_digit = w_disp_nxt[3:0];
         2'd1:    w_digit = w_disp_nxt[7:4];
         2'd2:    w_digit = w_disp_nxt[11:8];
         default: w_digit = w_disp_nxt[15:12];
      endcase
`ifdef SPEED_DISPLAY_BLANK_EN
      case (w_idx_nxt)
         2'd3:    w_blank = (w_disp_nxt[15:12] == 4'd0);
         2'd2:    w_blank = (w_disp_nxt[15:8] == 8'd0);
         2'd1:    w_blank = (w_disp_nxt[15:4] == 12'd0);
         default: w_blank = 1'b0;
      endcase
`else
      w_blank = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh_cnt <= 16'd0;
         r_digit_idx   <= 2'd0;
         r_an          <= 4'b1110;
         r_seg         <= 7'b1000000;
      end else begin
         r_refresh_cnt <= w_wrap ? 16'd0 : r_refresh_cnt + 16'd1;
         r_digit_idx   <= w_idx_nxt;
         r_an          <= ~(4'b0001 << w_idx_nxt);
         r_seg         <= w_blank ? 7'b1111111 : seg_pattern(w_digit);
      end
   end

   assign input_speed_ack = r_ack;
   assign seg             = r_seg;
   assign an              = r_an;

endmodule

// File: tb/tb_speed_display.sv
// Bench for speed_display: vector table of speed words with a scoreboard of expected display words,
// plus hand-written back-to-back and reset-abort sequences.
module tb_speed_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] input_speed;
   logic        input_speed_stb;
   logic        input_speed_ack;
   logic [6:0]  seg;
   logic [3:0]  an;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] speed;
      logic [15:0] bcd;
      string       name;
   } vec_t;

   vec_t vecs[7];

   speed_display #(.REFRESH_DIV(DIV)) dut (
      .clk             (clk),
      .rst             (rst),
      .input_speed     (input_speed),
      .input_speed_stb (input_speed_stb),
      .input_speed_ack (input_speed_ack),
      .seg             (seg),
      .an              (an)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] pat(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int k);
      logic [15:0] upper;
      upper = bcd >> (4 * k);
`ifdef SPEED_DISPLAY_BLANK_EN
      if (k > 0 && upper == 16'd0) return 7'b1111111;
`endif
      return pat(upper[3:0]);
   endfunction

   // Samples 16 consecutive negedges (one full scan at DIV=4) and compares each digit seen.
   task automatic scan_check(input string name, input logic [15:0] bcd);
      logic [6:0] seen[4];
      bit         got[4];
      int         k;
      for (int i = 0; i < 4; i++) begin
         got[i]  = 1'b0;
         seen[i] = 7'h00;
      end
      for (int i = 0; i < 16; i++) begin
         case (an)
            4'b1110: k = 0;
            4'b1101: k = 1;
            4'b1011: k = 2;
            4'b0111: k = 3;
            default: k = -1;
         endcase
         if (k < 0) check($sformatf("%s_an_onehot", name), {28'd0, an}, 32'h0000000e);
         else if (!got[k]) begin
            got[k]  = 1'b1;
            seen[k] = seg;
         end
         @(negedge clk);
      end
      for (int j = 0; j < 4; j++) begin
         if (!got[j]) check($sformatf("%s_digit%0d_seen", name, j), 32'd0, 32'd1);
         else check($sformatf("%s_digit%0d_seg", name, j), {25'd0, seen[j]}, {25'd0, exp_seg(bcd, j)});
      end
   endtask

   // Counts negedges with ack low until it rises; returns 99 if it never does.
   task automatic count_ack_low(output int lows);
      lows = 0;
      while (!input_speed_ack && lows < 40) begin
         lows++;
         @(negedge clk);
      end
      if (!input_speed_ack) lows = 99;
   endtask

   task automatic send(input logic [15:0] v, input logic [15:0] bcd, input string name);
      int          lows;
      logic [15:0] e;
      check({name, "_ack_idle"}, {31'd0, input_speed_ack}, 32'd1);
      input_speed     = v;
      input_speed_stb = 1'b1;
      exp_q.push_back(bcd);
      @(negedge clk);
      input_speed_stb = 1'b0;
      count_ack_low(lows);
      check({name, "_ack_low_cycles"}, lows, 32'd17);
      e = exp_q.pop_front();
      scan_check(name, e);
   endtask

   initial begin
      int          lows;
      logic [15:0] e;

      vecs[0] = '{16'd1234,  16'h1234, "v1234"};
      vecs[1] = '{16'd10000, 16'h9999, "v10000"};
      vecs[2] = '{16'd65535, 16'h9999, "v65535"};
      vecs[3] = '{16'd9999,  16'h9999, "v9999"};
      vecs[4] = '{16'd305,   16'h0305, "v305"};
      vecs[5] = '{16'd7,     16'h0007, "v7"};
      vecs[6] = '{16'd0,     16'h0000, "v0"};

      rst             = 1'b1;
      input_speed     = 16'd0;
      input_speed_stb = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and free-running scan.
      check("rst_ack", {31'd0, input_speed_ack}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("rst_an_%0d", k), {28'd0, an}, {28'd0, ~(4'b0001 << (k / 4))});
         check($sformatf("rst_seg_%0d", k), {25'd0, seg}, 32'h40);
         @(negedge clk);
      end

      for (int i = 0; i < 7; i++) send(vecs[i].speed, vecs[i].bcd, vecs[i].name);

      // Strobe held high across two words: the second is taken exactly when ack returns.
      check("b2b_ack_idle", {31'd0, input_speed_ack}, 32'd1);
      input_speed     = 16'd42;
      input_speed_stb = 1'b1;
      exp_q.push_back(16'h0042);
      @(negedge clk);
      input_speed = 16'd77;
      exp_q.push_back(16'h0077);
      count_ack_low(lows);
      check("b2b_first_ack_low_cycles", lows, 32'd17);
      @(negedge clk);
      input_speed_stb = 1'b0;
      check("b2b_second_ack_taken", {31'd0, input_speed_ack}, 32'd0);
      e = exp_q.pop_front();
      scan_check("b2b_42", e);
      count_ack_low(lows);
      check("b2b_second_done_timing", lows, 32'd1);
      e = exp_q.pop_front();
      scan_check("b2b_77", e);

      // Reset in the middle of converting 5678 discards the word.
      check("abort_ack_idle", {31'd0, input_speed_ack}, 32'd1);
      input_speed     = 16'd5678;
      input_speed_stb = 1'b1;
      @(negedge clk);
      input_speed_stb = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(16'h0000);
      check("abort_ack_after_rst", {31'd0, input_speed_ack}, 32'd1);
      check("abort_an_after_rst", {28'd0, an}, 32'he);
      check("abort_seg_after_rst", {25'd0, seg}, 32'h40);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         if (!input_speed_ack) lows++;
         @(negedge clk);
      end
      check("abort_ack_stays_high", lows, 32'd0);
      e = exp_q.pop_front();
      scan_check("abort_disp", e);

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/speed_display.md
SPEED_DISPLAY -- requirements
Module: speed_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, number of clk cycles each digit is displayed (legal range 2..65535).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: input_speed  input  16  unsigned speed word from the speed-measurement stage.
REQ-005 Port: input_speed_stb  input  1  producer strobe; input_speed valid while high.
REQ-006 Port: input_speed_ack  output  1  consumer acknowledge; high when a word can be accepted.
REQ-007 Port: seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 Port: an  output  4  digit select, active-low, one-hot; an[0] = units, an[3] = thousands.

Function
REQ-009 The block SHALL accept a word only in a cycle where input_speed_stb and input_speed_ack are both high.
REQ-010 The block SHALL use a state machine with states IDLE, CONVERT and LOAD.
REQ-011 IDLE: input_speed_ack = 1; on transfer, capture input_speed, drive ack low next cycle, go to CONVERT.
REQ-012 Captured value > 9999 SHALL be clamped to 9999 before conversion.
REQ-013 CONVERT: binary-to-BCD shift-add-3 (double dabble), one bit per cycle, exactly 16 cycles, then go to LOAD.
REQ-014 LOAD: copy the four BCD digits into the display register in one cycle, then go to IDLE.
REQ-015 For a transfer in cycle T, ack SHALL be low T+1..T+17, the display register SHALL be updated at the edge ending T+17, and ack SHALL be high again at T+18.
REQ-016 Strobe held high while busy SHALL be ignored; the word SHALL be accepted at the next IDLE cycle.
REQ-017 The display register SHALL hold its value until the next LOAD; input words are never dropped once acknowledged.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL select the current digit index; seg SHALL show that digit's pattern in the same cycle (registered outputs, no glitch between index and pattern).
REQ-020 Segment patterns for digits 0..9 (gfedcba, active-low): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 The refresh scan SHALL run continuously and independently of the handshake and conversion.

Reset
REQ-022 On rst: state = IDLE, input_speed_ack = 1 from the cycle after rst, and display register = 0000.
REQ-023 On rst: refresh counter = 0, digit index = 0, an = 1110, seg = 1000000.
REQ-024 Reset during CONVERT or LOAD SHALL abort the conversion with no display update; the word in flight is discarded.

Configuration
REQ-025 Macro SPEED_DISPLAY_BLANK_EN: when defined, leading-zero digits (thousands, hundreds, tens) SHALL show all segments off (1111111).
REQ-026 With SPEED_DISPLAY_BLANK_EN defined, the units digit SHALL never be blanked, so value 0 shows "   0".
REQ-027 Without SPEED_DISPLAY_BLANK_EN, all four digits SHALL always be shown, including leading zeros.

Verification
REQ-028 Reset, REFRESH_DIV=4 -> ack=1; an cycles 1110,1101,1011,0111 every 4 clocks; seg=1000000 on every digit.
REQ-029 Send 1234 at cycle T -> ack low T+1..T+17, high at T+18; digits 4,3,2,1 on an[0..3]; seg for units = 0011001.
REQ-030 Send 10000, then 65535 -> display 9999 both times.
REQ-031 Hold stb high with 42 then 77 back-to-back -> 42 displayed, then 77 accepted exactly at the next IDLE; both acks seen.
REQ-032 Assert rst at T+8 during conversion of 5678 -> display stays 0000 and ack=1 the cycle after rst.
REQ-033 With SPEED_DISPLAY_BLANK_EN, send 7 -> an[3..1] show 1111111, an[0] shows 1111000; send 0 -> units shows 1000000.
